// File: rtl/maverickone_reg_lock_tracker_pkg.sv
// Shared sizing and types for the register lock tracker.
// Register count and in-flight writer limit live here so launcher and tracker agree.
package maverickone_reg_lock_tracker_pkg;

    localparam int NUM_REGS        = 16;
    localparam int NUM_OUTSTANDING = 4;
    localparam int REG_W           = $clog2(NUM_REGS);

    typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/maverickone_reg_lock_tracker_lock_counter.sv
// Up/down outstanding-writer counter; registered count, combinational flags.
// Simultaneous inc and dec cancel; a dec at zero holds the count and raises underflow_o.
module maverickone_reg_lock_tracker_lock_counter
    import maverickone_reg_lock_tracker_pkg::*;
#(
    parameter int W = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         nz_o,
    output logic         underflow_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (inc_i && !dec_i) begin
            cnt_o <= cnt_o + W'(1);
        end else if (dec_i && !inc_i && nz_o) begin
            cnt_o <= cnt_o - W'(1);
        end
    end

    assign nz_o        = (cnt_o != '0);
    assign underflow_o = dec_i && !inc_i && !nz_o;

endmodule

// File: rtl/maverickone_reg_lock_tracker.sv
// Per-register lock scoreboard between launcher handshake and writeback port.
// Locks visible one cycle after launch; launch_ready_o drops when the global or per-register limit is reached.
module maverickone_reg_lock_tracker
    import maverickone_reg_lock_tracker_pkg::*;
#(
    parameter  int NR  = NUM_REGS,
    parameter  int NOS = NUM_OUTSTANDING,
    localparam int RW  = $clog2(NR),
    localparam int CW  = $clog2(NOS + 1)
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          clear_i,
    input  logic          launch_valid_i,
    input  logic [RW-1:0] launch_rd_i,
    output logic          launch_ready_o,
    input  logic          wb_valid_i,
    input  logic [RW-1:0] wb_rd_i,
    output logic          wb_ready_o,
    output logic [NR-1:0] locks_o,
    output logic [CW-1:0] outstanding_o,
    output logic          error_o
);

    logic [CW-1:0] cnt [NR];
    logic [NR-1:0] nz;
    logic [NR-1:0] uflow;
    logic [NR-1:0] inc_vec;
    logic [NR-1:0] dec_vec;
    logic          launch_hit;
    logic          wb_hit;
    logic          paired;
    logic          tot_dec;
    logic          tot_nz;
    logic          tot_uflow;

    assign launch_ready_o = (outstanding_o != CW'(NOS)) && (cnt[launch_rd_i] != CW'(NOS));
    assign launch_hit     = launch_valid_i && launch_ready_o && (launch_rd_i != '0);
    assign wb_hit         = wb_valid_i && (wb_rd_i != '0);
    assign paired         = launch_hit && wb_hit && (launch_rd_i == wb_rd_i);
    assign wb_ready_o     = 1'b1;

    // Register 0 is hardwired zero and never tracked.
    assign cnt[0]     = '0;
    assign nz[0]      = 1'b0;
    assign uflow[0]   = 1'b0;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;

    for (genvar r = 1; r < NR; r++) begin : g_reg
        assign inc_vec[r] = launch_hit && (launch_rd_i == RW'(r));
        assign dec_vec[r] = wb_hit && (wb_rd_i == RW'(r));

        maverickone_reg_lock_tracker_lock_counter #(.W(CW)) u_cnt (
            .clk_i       (clk_i),
            .arst_i      (arst_i),
            .clear_i     (clear_i),
            .inc_i       (inc_vec[r]),
            .dec_i       (dec_vec[r]),
            .cnt_o       (cnt[r]),
            .nz_o        (nz[r]),
            .underflow_o (uflow[r])
        );
    end

    // A same-register launch/writeback pair cancels, so the total decrements
    // whenever the writeback retires a real writer or is absorbed by that pair.
    assign tot_dec = wb_hit && (nz[wb_rd_i] || paired);

    maverickone_reg_lock_tracker_lock_counter #(.W(CW)) u_tot (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .clear_i     (clear_i),
        .inc_i       (launch_hit),
        .dec_i       (tot_dec),
        .cnt_o       (outstanding_o),
        .nz_o        (tot_nz),
        .underflow_o (tot_uflow)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            error_o <= 1'b0;
        end else if (clear_i) begin
            error_o <= 1'b0;
        end else if (|uflow) begin
            error_o <= 1'b1;
        end
    end

    assign locks_o = nz;

    logic unused_ok;
    assign unused_ok = ^{tot_nz, tot_uflow};

endmodule

// File: tb/tb_maverickone_reg_lock_tracker.sv
// Randomised and directed bench for the register lock tracker against a count-per-register model.
module tb_maverickone_reg_lock_tracker;

    localparam int NR  = 16;
    localparam int NOS = 4;

    logic        clk    = 1'b0;
    logic        arst   = 1'b1;
    logic        clear  = 1'b0;
    logic        lv     = 1'b0;
    logic        wv     = 1'b0;
    logic [3:0]  lrd    = 4'd0;
    logic [3:0]  wrd    = 4'd0;
    logic        lready;
    logic        wready;
    logic [15:0] locks;
    logic [2:0]  outst;
    logic        err;

    int m_cnt [NR];
    int m_tot;
    bit m_err;
    int n_vec  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    maverickone_reg_lock_tracker dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .clear_i        (clear),
        .launch_valid_i (lv),
        .launch_rd_i    (lrd),
        .launch_ready_o (lready),
        .wb_valid_i     (wv),
        .wb_rd_i        (wrd),
        .wb_ready_o     (wready),
        .locks_o        (locks),
        .outstanding_o  (outst),
        .error_o        (err)
    );

    function automatic bit m_ready(input int rd);
        return (m_tot != NOS) && (m_cnt[rd] != NOS);
    endfunction

    function automatic logic [15:0] m_locks();
        logic [15:0] v;
        v = '0;
        for (int r = 1; r < NR; r++) v[r] = (m_cnt[r] != 0);
        return v;
    endfunction

    // Model: a writer count per register; a launch adds one, a writeback removes one.
    always @(posedge clk or posedge arst) begin
        if (arst || clear) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_tot = 0;
            m_err = 1'b0;
        end else begin
            bit acc;
            bit wbh;
            acc = lv && m_ready(int'(lrd)) && (lrd != 0);
            wbh = wv && (wrd != 0);
            if (!(acc && wbh && lrd == wrd)) begin
                if (wbh) begin
                    if (m_cnt[wrd] > 0) begin
                        m_cnt[wrd]--;
                        m_tot--;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (acc) begin
                    m_cnt[lrd]++;
                    m_tot++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locks",       32'(locks),  32'(m_locks()));
            check("outstanding", 32'(outst),  32'(m_tot));
            check("error",       32'(err),    32'(m_err));
            check("launch_ready",32'(lready), 32'(m_ready(int'(lrd))));
            check("wb_ready",    32'(wready), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l_v, input logic [3:0] l_rd, input logic w_v,
                         input logic [3:0] w_rd, input logic clr);
        lv    = l_v;
        lrd   = l_rd;
        wv    = w_v;
        wrd   = w_rd;
        clear = clr;
    endtask

    initial begin
        #12;
        check("rst_locks", 32'(locks),  32'd0);
        check("rst_outst", 32'(outst),  32'd0);
        check("rst_err",   32'(err),    32'd0);
        check("rst_ready", 32'(lready), 32'd1);
        arst   = 1'b0;
        chk_en = 1'b1;

        // launch 5, writeback three cycles later
        drive(1, 5, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("l5_lock",  32'(locks[5]), 32'd1);
        check("l5_outst", 32'(outst),    32'd1);
        step(); step();
        check("l5_hold",  32'(locks[5]), 32'd1);
        drive(0, 0, 1, 5, 0); step();
        drive(0, 0, 0, 0, 0);
        check("w5_lock",  32'(locks[5]), 32'd0);
        check("w5_outst", 32'(outst),    32'd0);

        // simultaneous launch and writeback on 7
        drive(1, 7, 0, 0, 0); step();
        drive(1, 7, 1, 7, 0); step();
        drive(0, 0, 0, 0, 0);
        check("p7_lock",  32'(locks[7]), 32'd1);
        check("p7_outst", 32'(outst),    32'd1);
        drive(0, 0, 1, 7, 0); step();
        drive(0, 0, 0, 0, 0);
        check("p7_drain", 32'(outst),    32'd0);

        // fill register 3 to the limit
        for (int i = 0; i < NOS; i++) begin
            drive(1, 3, 0, 0, 0); step();
        end
        drive(0, 3, 0, 0, 0); #1;
        check("r3_full_rdy", 32'(lready), 32'd0);
        drive(1, 3, 0, 0, 0); step();
        drive(0, 3, 0, 0, 0);
        check("r3_reject", 32'(outst), 32'd4);
        drive(0, 3, 1, 3, 0); step();
        drive(0, 3, 0, 0, 0); #1;
        check("r3_restore", 32'(lready), 32'd1);
        for (int i = 0; i < NOS - 1; i++) begin
            drive(0, 0, 1, 3, 0); step();
        end

        // register 0 is never tracked
        drive(1, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("r0_locks", 32'(locks), 32'd0);
        check("r0_outst", 32'(outst), 32'd0);
        check("r0_err",   32'(err),   32'd0);

        // writeback to an unlocked register, then clear
        drive(1, 2, 0, 0, 0); step();
        drive(0, 0, 1, 9, 0); step();
        drive(0, 0, 0, 0, 0);
        check("w9_err", 32'(err), 32'd1);
        step();
        check("w9_sticky", 32'(err), 32'd1);
        drive(1, 4, 1, 2, 1); step();
        drive(0, 0, 0, 0, 0);
        check("clr_err",   32'(err),   32'd0);
        check("clr_locks", 32'(locks), 32'd0);
        check("clr_outst", 32'(outst), 32'd0);

        // random traffic over a few registers to exercise limits and pairing
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                  1'($urandom_range(0, 63) == 0));
            if (i == 1500) begin
                #2;
                arst = 1'b1;
                #1;
                check("arst_locks", 32'(locks), 32'd0);
                check("arst_outst", 32'(outst), 32'd0);
                check("arst_err",   32'(err),   32'd0);
                arst = 1'b0;
            end
            step();
        end

        drive(0, 0, 0, 0, 0);
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
